// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 transmitter. Sends one command byte to the
//            device over the shared open-drain PS2C/PS2D lines. The sequence
//            is: inhibit, request-to-send, 8 data bits LSB first, odd parity,
//            stop, then a check for the device ACK. The lines are driven only
//            through active-low enables, and the top level maps them onto
//            tri-states.
// Ports    : clk, rst (async, active-high)
//            tx_data/tx_valid/tx_ready  - byte request handshake
//            PS2C/PS2D                  - raw pin levels
//            ps2c_drive_low/ps2d_drive_low - 1 = pull line low
//            busy                       - accept .. return to IDLE
//            done/ack_err/timeout_err   - 1-cycle completion pulses
// Config   : `define PS2_TX_RETRY_EN to retry failed attempts up to RETRY_MAX
//            extra times before an error is reported.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8,
  parameter int RETRY_MAX      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t               r_state;
  logic [FILTER_LEN-1:0] r_c_sh, r_d_sh;
  logic                 r_c_filt, r_d_filt, r_c_prev;
  logic [7:0]           r_data;
  logic                 r_par;
  logic [3:0]           r_bitcnt;
  logic [c_INH_W-1:0]   r_inh_cnt;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic                 r_tx_ready, r_busy, r_c_drv, r_d_drv;
  logic                 r_done, r_ack_err, r_timeout_err;

  logic w_fall, w_active, w_to_hit, w_ack_fail, w_fail, w_can_retry;

  // Glitch filter: the filtered level only moves once the whole window agrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_sh   <= '1;
      r_d_sh   <= '1;
      r_c_filt <= 1'b1;
      r_d_filt <= 1'b1;
      r_c_prev <= 1'b1;
    end else begin
      r_c_sh   <= {r_c_sh[FILTER_LEN-2:0], PS2C};
      r_d_sh   <= {r_d_sh[FILTER_LEN-2:0], PS2D};
      if (&r_c_sh)       r_c_filt <= 1'b1;
      else if (~|r_c_sh) r_c_filt <= 1'b0;
      if (&r_d_sh)       r_d_filt <= 1'b1;
      else if (~|r_d_sh) r_d_filt <= 1'b0;
      r_c_prev <= r_c_filt;
    end
  end

  assign w_fall     = r_c_prev & ~r_c_filt;
  assign w_active   = (r_state == S_REQ) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_to_hit   = w_active && (r_to_cnt == c_TO_LAST);
  assign w_ack_fail = (r_state == S_ACK) && w_fall && r_d_filt;
  assign w_fail     = w_to_hit || w_ack_fail;

`ifdef PS2_TX_RETRY_EN
  localparam int c_RTY_W = $clog2(RETRY_MAX + 2);
  logic [c_RTY_W-1:0] r_retry;

  assign w_can_retry = (r_retry != c_RTY_W'(RETRY_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_retry <= '0;
    else if (r_state == S_IDLE)      r_retry <= '0;
    else if (w_fail && w_can_retry)  r_retry <= r_retry + 1'b1;
  end
`else
  assign w_can_retry = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_data        <= '0;
      r_par         <= 1'b0;
      r_bitcnt      <= '0;
      r_inh_cnt     <= '0;
      r_to_cnt      <= '0;
      r_tx_ready    <= 1'b1;
      r_busy        <= 1'b0;
      r_c_drv       <= 1'b0;
      r_d_drv       <= 1'b0;
      r_done        <= 1'b0;
      r_ack_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_ack_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_data     <= tx_data;
            r_par      <= ~^tx_data;
            r_bitcnt   <= '0;
            r_inh_cnt  <= '0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_c_drv    <= 1'b1;
            r_d_drv    <= 1'b0;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          // Clock edges seen here are our own pull-down and are not acted on.
          if (r_inh_cnt == c_INH_LAST) begin
            r_c_drv  <= 1'b0;
            r_d_drv  <= 1'b1;      // start bit
            r_to_cnt <= '0;
            r_state  <= S_REQ;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        default: begin
          if (w_fail) begin
            if (w_can_retry) begin
              r_inh_cnt <= '0;
              r_bitcnt  <= '0;
              r_c_drv   <= 1'b1;
              r_d_drv   <= 1'b0;
              r_state   <= S_INHIBIT;
            end else begin
              r_tx_ready    <= 1'b1;
              r_busy        <= 1'b0;
              r_c_drv       <= 1'b0;
              r_d_drv       <= 1'b0;
              r_ack_err     <= w_ack_fail && !w_to_hit;
              r_timeout_err <= w_to_hit;
              r_state       <= S_IDLE;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            case (r_state)
              S_REQ: begin
                // r_bitcnt holds the number of falls already seen.
                if (w_fall) begin
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt < 4'd8) begin
                    r_d_drv <= ~r_data[r_bitcnt[2:0]];
                  end else if (r_bitcnt == 4'd8) begin
                    r_d_drv <= ~r_par;
                  end else begin
                    r_d_drv <= 1'b0;   // stop bit: release
                    r_state <= S_ACK;
                  end
                end
              end
              S_ACK: begin
                // A high data line at this fall is taken by w_ack_fail.
                if (w_fall) r_state <= S_WAIT_IDLE;
              end
              S_WAIT_IDLE: begin
                if (r_c_filt && r_d_filt) begin
                  r_done     <= 1'b1;
                  r_tx_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
                end
              end
              default: begin
                r_tx_ready <= 1'b1;
                r_busy     <= 1'b0;
                r_c_drv    <= 1'b0;
                r_d_drv    <= 1'b0;
                r_state    <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx_ready       = r_tx_ready;
  assign busy           = r_busy;
  assign ps2c_drive_low = r_c_drv;
  assign ps2d_drive_low = r_d_drv;
  assign done           = r_done;
  assign ack_err        = r_ack_err;
  assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with a PS/2 device model on
//            an open-drain bus, a scoreboard of expected outcomes and a
//            monitor that checks every completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH       = 50;
  localparam int TOUT      = 3000;
  localparam int FLEN      = 8;
  localparam int RETRY_MAX = 2;
  localparam int H         = 20;   // device half clock period in clk cycles
`ifdef PS2_TX_RETRY_EN
  localparam int N_ATT = RETRY_MAX + 1;
`else
  localparam int N_ATT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2c_drive_low, ps2d_drive_low, busy, done, ack_err, timeout_err;
  logic       dev_c_low = 1'b0, dev_d_low = 1'b0;
  logic       bus_c, bus_d;

  assign bus_c = ~(ps2c_drive_low | dev_c_low);
  assign bus_d = ~(ps2d_drive_low | dev_d_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .FILTER_LEN(FLEN), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .PS2C(bus_c), .PS2D(bus_d), .ps2c_drive_low(ps2c_drive_low),
    .ps2d_drive_low(ps2d_drive_low), .busy(busy), .done(done), .ack_err(ack_err),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: kind 0 = done, 1 = ack_err, 2 = timeout_err
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         att;
  } exp_t;
  exp_t sb[$];

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // ---------------- device model ----------------
  int         dev_mode  = 0;   // 0 ACK, 1 no ACK, 2 never clocks
  logic       glitch_en = 1'b0;
  logic       dev_abort = 1'b0;
  int         dev_fall_cnt = 0;
  logic [7:0] dev_byte = '0;
  logic       dev_par = 1'b0, dev_stop = 1'b0;

  task automatic dwait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) dev_abort = 1'b1;
    end
  endtask

  task automatic run_frame();
    logic [9:0] cap;
    cap = '0;
    dev_abort = 1'b0;
    dev_fall_cnt = 0;
    dwait(H);
    if (dev_abort) begin dev_c_low = 0; dev_d_low = 0; return; end
    for (int k = 1; k <= 10; k++) begin
      dev_c_low = 1'b1;
      dev_fall_cnt = k;
      dwait(H);
      if (dev_abort) begin dev_c_low = 0; dev_d_low = 0; dev_fall_cnt = 0; return; end
      dev_c_low = 1'b0;
      cap[k-1] = bus_d;
      if (glitch_en && k == 5) begin
        dwait(5); dev_c_low = 1'b1; dwait(3); dev_c_low = 1'b0; dwait(H - 8);
      end else begin
        dwait(H);
      end
      if (dev_abort) begin dev_c_low = 0; dev_d_low = 0; dev_fall_cnt = 0; return; end
    end
    dev_byte = cap[7:0];
    dev_par  = cap[8];
    dev_stop = cap[9];
    if (dev_mode == 0) dev_d_low = 1'b1;
    dwait(H / 2);
    dev_c_low = 1'b1;
    dev_fall_cnt = 11;
    dwait(H);
    dev_c_low = 1'b0;
    dwait(H / 2);
    dev_d_low = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ps2d_drive_low && !ps2c_drive_low) begin
        if (dev_mode == 2) begin
          while (ps2d_drive_low && !rst) @(negedge clk);
        end else begin
          run_frame();
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_c = 1'b0;
  int   inh_len = 0, inh_phases = 0, req_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (rst) begin
      inh_len = 0; inh_phases = 0; prev_c = 1'b0;
    end else begin
      if (ps2c_drive_low) inh_len++;
      if (prev_c && !ps2c_drive_low) begin
        chk("inhibit_len", inh_len, INH);
        chk("start_bit_drive", ps2d_drive_low, 1);
        inh_phases++;
        inh_len = 0;
        req_cyc = cyc;
      end
      prev_c = ps2c_drive_low;
      if (done || ack_err || timeout_err) begin
        kind = done ? 0 : (ack_err ? 1 : 2);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {29'd0, done, ack_err, timeout_err}, 0);
        end else begin
          e = sb.pop_front();
          chk("single_pulse", $countones({done, ack_err, timeout_err}), 1);
          chk("outcome_kind", kind, e.kind);
          chk("attempts", inh_phases, e.att);
          chk("lines_released", {ps2c_drive_low, ps2d_drive_low}, 0);
          chk("ready_after", {tx_ready, busy}, 2'b10);
          if (e.kind != 2) begin
            chk("rx_byte", dev_byte, e.data);
            chk("rx_parity", dev_par, odd_par(e.data));
            chk("rx_stop", dev_stop, 1);
          end else begin
            chk("timeout_latency", cyc - req_cyc, TOUT);
          end
        end
        inh_phases = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input int kind, input int att, input bit push);
    exp_t e;
    @(negedge clk);
    chk("ready_before", tx_ready, 1);
    if (push) begin
      e.kind = kind; e.data = b; e.att = att;
      sb.push_back(e);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready_busy", {tx_ready, busy}, 2'b01);
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  task automatic wait_outcome();
    for (int i = 0; i < 30000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("outcome_wait_expired", sb.size(), 0);
      sb.delete();
    end
    repeat (100) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int         m;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_drive", {ps2c_drive_low, ps2d_drive_low}, 0);
    chk("rst_pulses", {done, ack_err, timeout_err}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_ready", {tx_ready, busy, ps2c_drive_low, ps2d_drive_low}, 4'b1000);

    dev_mode = 0; send(8'hED, 0, 1, 1'b1); wait_outcome();
    dev_mode = 0; send(8'h00, 0, 1, 1'b1); wait_outcome();
    dev_mode = 1; send(8'hFF, 1, N_ATT, 1'b1); wait_outcome();
    dev_mode = 2; send(8'($urandom), 2, N_ATT, 1'b1); wait_outcome();

    // Reset in the middle of data bit 4.
    dev_mode = 0;
    send(8'h00, 0, 1, 1'b0);
    for (int i = 0; i < 3000 && dev_fall_cnt != 4; i++) @(negedge clk);
    chk("reached_bit4", dev_fall_cnt, 4);
    repeat (12) @(negedge clk);
    chk("bit4_driven", ps2d_drive_low, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_drive", {ps2c_drive_low, ps2d_drive_low}, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("post_rst_idle", {tx_ready, busy}, 2'b10);

    // Glitch on PS2C plus requests while busy.
    glitch_en = 1'b1;
    send(8'hF4, 0, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      repeat (30) @(negedge clk);
      tx_data = 8'($urandom); tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    wait_outcome();
    glitch_en = 1'b0;
    chk("no_second_frame", {tx_ready, busy, ps2c_drive_low}, 3'b100);

    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      m = int'($urandom_range(0, 1));
      dev_mode = m;
      send(b, m, (m == 1) ? N_ATT : 1, 1'b1);
      wait_outcome();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared PS2C/PS2D open-drain lines.
- Implements the full sequence: inhibit, request-to-send, clocking 8 data bits plus parity and stop, device ACK check.
- Sits beside the existing PS/2 receiver on the same pins. Drives the lines only through active-low enables; the top level ties them to tri-states.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2C is held low before request (100 us at 100 MHz)
- TIMEOUT_CYCLES, 2000000, max clk cycles from request to ACK completion (20 ms)
- FILTER_LEN, 8, glitch-filter depth for PS2C/PS2D samples
- RETRY_MAX, 2, extra attempts; used only with PS2_TX_RETRY_EN

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tx_data  in  8  byte to send, sampled on accept
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high in IDLE only
- PS2C  in  1  raw PS/2 clock pin level
- PS2D  in  1  raw PS/2 data pin level
- ps2c_drive_low  out  1  1 = pull PS2C low, 0 = release
- ps2d_drive_low  out  1  1 = pull PS2D low, 0 = release
- busy  out  1  high from accept until return to IDLE
- done  out  1  1-cycle pulse: frame sent, ACK seen
- ack_err  out  1  1-cycle pulse: no ACK at 11th falling edge
- timeout_err  out  1  1-cycle pulse: TIMEOUT_CYCLES exceeded

Behaviour:
- Reset: async, active-high. Values: state IDLE, tx_ready=1, busy=0, both drive_low=0, all pulses 0, filtered clock/data=1, filter shift regs all-ones, counters 0.
- Filter:
  - Each clk, shift in the raw pin into a FILTER_LEN register.
  - The filtered level updates only when all bits are equal; otherwise it holds.
  - Falling edge = previous filtered PS2C 1 and current 0.
- Parity: odd, p = ~^data, computed at accept.
- States:
  - IDLE: tx_ready=1. On accept: latch byte and parity, bitcnt=0, go INHIBIT. tx_ready drops the cycle after accept.
  - INHIBIT: ps2c_drive_low=1 for exactly INHIBIT_CYCLES cycles, then go REQ.
  - REQ: ps2d_drive_low=1 (start bit 0), ps2c_drive_low=0 in the same cycle. Timeout counter starts. On each filtered falling edge, the host presents the next bit:
    - falls 1–8: data bits LSB first; ps2d_drive_low = ~bit
    - fall 9: parity
    - fall 10: stop, ps2d_drive_low=0
  - ACK: on fall 11, sample filtered PS2D.
    - 0 → WAIT_IDLE.
    - 1 → ack_err pulse, release lines, go IDLE.
  - WAIT_IDLE: wait for filtered PS2C=1 and PS2D=1, then done pulse, go IDLE.
- Timeout: counter runs in REQ/ACK/WAIT_IDLE. When it reaches TIMEOUT_CYCLES: timeout_err pulse, both drive_low=0 next cycle, IDLE.
- Boundaries:
  - tx_valid while busy is ignored; no queueing.
  - tx_data changes after accept do not affect the frame.
  - Reset mid-frame releases both lines immediately (async).
  - The receiver sees our own frame only as clock activity. The top level must ignore receiver output while busy.
  - A falling edge during INHIBIT is ignored (we are driving the line).
- Latency: accept→REQ = INHIBIT_CYCLES+1 clk. done asserts ≥1 clk after the bus is idle following ACK.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On ACK failure or timeout, re-enter INHIBIT with the latched byte, up to RETRY_MAX extra times.
  - ack_err/timeout_err pulse only after the final attempt fails.
  - busy stays high throughout.
  - done pulses once on the first successful attempt.
- Undefined: a single attempt; errors are reported immediately; RETRY_MAX is unused.

Test Plan:
- Send 0xED with a device model (10 kHz clock, ACK low on 11th): PS2C held low 10000 clk; data bits on pins 1,0,1,1,0,1,1,1; parity=1; stop=1 → done pulse, ack_err=0.
- Send 0x00: parity bit = 1, all data bits drive low; ACK given → done=1.
- Send 0xFF, device never ACKs (PS2D high at fall 11) → ack_err 1-cycle pulse, both drive_low=0, tx_ready=1.
- Device never clocks after REQ → timeout_err exactly TIMEOUT_CYCLES after REQ entry, lines released. With PS2_TX_RETRY_EN: 3 inhibit phases, then one timeout_err.
- Assert rst during data bit 4 → ps2c/ps2d_drive_low=0 same cycle, busy=0. A new 0xF4 after reset completes with done.
- 3-clk glitch on PS2C mid-frame plus tx_valid pulses while busy → no bit advance, no second frame started.
